// File: rtl/ysyx_23060124_ifu_fetch.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ysyx_23060124_ifu_fetch: PC holder, single-outstanding AR/R reader and    |
// | valid/ready producer toward decode. Optional YSYX_23060124_IFU_PERF_EN.   |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module ysyx_23060124_ifu_fetch #(
   parameter int unsigned        ISA_W    = 32,
   parameter logic [ISA_W-1:0]   RESET_PC = 32'h8000_0000
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_redirect,
   input  logic [ISA_W-1:0] i_redirect_pc,
   output logic [ISA_W-1:0] o_araddr,
   output logic             o_arvalid,
   input  logic             i_arready,
   input  logic [ISA_W-1:0] i_rdata,
   input  logic [1:0]       i_rresp,
   input  logic             i_rvalid,
   output logic             o_rready,
   output logic [ISA_W-1:0] o_ins,
   output logic [ISA_W-1:0] o_pc,
   output logic             o_valid,
   input  logic             i_ready,
   output logic             o_fetch_err
`ifdef YSYX_23060124_IFU_PERF_EN
   ,
   output logic [31:0]      o_perf_fetch,
   output logic [31:0]      o_perf_stall
`endif
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_RESP = 2'd2,
      S_OUT  = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [ISA_W-1:0] pc_q, pc_d;
   logic [ISA_W-1:0] araddr_q, araddr_d;
   logic             arvalid_q, arvalid_d;
   logic             rready_q, rready_d;
   logic             valid_q, valid_d;
   logic [ISA_W-1:0] ins_q, ins_d;
   logic [ISA_W-1:0] opc_q, opc_d;
   logic             err_q, err_d;
   logic             kill_q, kill_d;

   logic [ISA_W-1:0] redir_pc;
   logic             ar_hs, r_hs, d_hs;
   logic             unused_ok;

   assign redir_pc  = {i_redirect_pc[ISA_W-1:2], 2'b00};
   assign unused_ok = ^i_redirect_pc[1:0];
   assign ar_hs     = arvalid_q && i_arready;
   assign r_hs      = rready_q && i_rvalid;
   assign d_hs      = valid_q && i_ready;

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      araddr_d = araddr_q;
      ins_d    = ins_q;
      opc_d    = opc_q;
      err_d    = err_q;
      kill_d   = kill_q;

      if (r_hs && (i_rresp != 2'b00)) begin
         err_d = 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            state_d = S_REQ;
            if (i_redirect) begin
               pc_d = redir_pc;
            end
         end
         S_REQ: begin
            // The address phase already on the bus cannot be withdrawn, so
            // a redirect here only marks its eventual data as stale.
            if (i_redirect) begin
               pc_d   = redir_pc;
               kill_d = 1'b1;
            end
            if (ar_hs) begin
               state_d = S_RESP;
            end
         end
         S_RESP: begin
            if (r_hs) begin
               if (kill_q || i_redirect) begin
                  kill_d  = 1'b0;
                  state_d = S_REQ;
               end else begin
                  ins_d   = i_rdata;
                  opc_d   = pc_q;
                  state_d = S_OUT;
               end
            end else if (i_redirect) begin
               kill_d = 1'b1;
            end
            if (i_redirect) begin
               pc_d = redir_pc;
            end
         end
         S_OUT: begin
            if (i_redirect) begin
               pc_d    = redir_pc;
               state_d = S_REQ;
            end else if (d_hs) begin
               pc_d    = pc_q + ISA_W'(4);
               state_d = S_REQ;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Latch the address only on REQ entry so it stays put until accepted.
      if ((state_d == S_REQ) && (state_q != S_REQ)) begin
         araddr_d = pc_d;
      end

      arvalid_d = (state_d == S_REQ);
      rready_d  = (state_d == S_RESP);
      valid_d   = (state_d == S_OUT);
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q   <= S_IDLE;
         pc_q      <= RESET_PC;
         araddr_q  <= RESET_PC;
         arvalid_q <= 1'b0;
         rready_q  <= 1'b0;
         valid_q   <= 1'b0;
         ins_q     <= '0;
         opc_q     <= RESET_PC;
         err_q     <= 1'b0;
         kill_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         araddr_q  <= araddr_d;
         arvalid_q <= arvalid_d;
         rready_q  <= rready_d;
         valid_q   <= valid_d;
         ins_q     <= ins_d;
         opc_q     <= opc_d;
         err_q     <= err_d;
         kill_q    <= kill_d;
      end
   end

   assign o_araddr    = araddr_q;
   assign o_arvalid   = arvalid_q;
   assign o_rready    = rready_q;
   assign o_valid     = valid_q;
   assign o_ins       = ins_q;
   assign o_pc        = opc_q;
   assign o_fetch_err = err_q;

`ifdef YSYX_23060124_IFU_PERF_EN
   logic [31:0] perf_fetch_q, perf_fetch_d;
   logic [31:0] perf_stall_q, perf_stall_d;

   always_comb begin
      perf_fetch_d = perf_fetch_q;
      perf_stall_d = perf_stall_q;
      if (d_hs && (perf_fetch_q != 32'hFFFF_FFFF)) begin
         perf_fetch_d = perf_fetch_q + 32'd1;
      end
      if (((state_q == S_REQ) || (state_q == S_RESP)) && (perf_stall_q != 32'hFFFF_FFFF)) begin
         perf_stall_d = perf_stall_q + 32'd1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         perf_fetch_q <= '0;
         perf_stall_q <= '0;
      end else begin
         perf_fetch_q <= perf_fetch_d;
         perf_stall_q <= perf_stall_d;
      end
   end

   assign o_perf_fetch = perf_fetch_q;
   assign o_perf_stall = perf_stall_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ysyx_23060124_ifu_fetch.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_ysyx_23060124_ifu_fetch: directed + randomized bench with a memory     |
// | responder and a PC-sequence reference model. Revision: 1.0                |
// +--------------------------------------------------------------------------+
module tb_ysyx_23060124_ifu_fetch;

   localparam logic [31:0] RST_PC = 32'h8000_0000;

   logic        i_clk, i_rst, i_redirect, i_arready, i_rvalid, i_ready;
   logic [31:0] i_redirect_pc, i_rdata;
   logic [1:0]  i_rresp;
   logic [31:0] o_araddr, o_ins, o_pc;
   logic        o_arvalid, o_rready, o_valid, o_fetch_err;
`ifdef YSYX_23060124_IFU_PERF_EN
   logic [31:0] o_perf_fetch, o_perf_stall;
`endif

   ysyx_23060124_ifu_fetch dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc),
      .o_araddr(o_araddr), .o_arvalid(o_arvalid), .i_arready(i_arready),
      .i_rdata(i_rdata), .i_rresp(i_rresp), .i_rvalid(i_rvalid), .o_rready(o_rready),
      .o_ins(o_ins), .o_pc(o_pc), .o_valid(o_valid), .i_ready(i_ready),
      .o_fetch_err(o_fetch_err)
`ifdef YSYX_23060124_IFU_PERF_EN
      , .o_perf_fetch(o_perf_fetch), .o_perf_stall(o_perf_stall)
`endif
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   int n_err = 0, n_chk = 0;
   // memory responder state and knobs
   bit          pending = 0, fixed_data = 1, rnd_mode = 0;
   logic [31:0] paddr = '0;
   int          ar_cnt = 0, rwait = 0, ar_delay = 0, r_delay = 0;
   logic [1:0]  resp_knob = 2'b00;
   // reference model
   logic [31:0] exp_pc = RST_PC;
   bit          exp_err = 0;
   int          n_ar = 0, n_ar_wait = 0, n_deliv = 0;

   function automatic logic [31:0] memf(input logic [31:0] a);
      return fixed_data ? 32'h0000_0013 : ((a * 32'h9E37_79B1) ^ 32'h0000_0013);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_chk++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      logic p_arv, p_arr, p_rr, p_rv, p_v, p_rdy, p_redir, p_rst;
      logic [31:0] p_araddr, p_rpc;
      logic [1:0]  p_resp;
      p_arv = o_arvalid; p_arr = i_arready; p_rr = o_rready; p_rv = i_rvalid;
      p_v = o_valid; p_rdy = i_ready; p_redir = i_redirect; p_rst = i_rst;
      p_araddr = o_araddr; p_rpc = i_redirect_pc; p_resp = i_rresp;
      @(posedge i_clk);
      #1;
      i_redirect = 1'b0;
      if (p_rst) begin
         exp_pc = RST_PC; exp_err = 0; pending = 0; ar_cnt = 0;
         chk("rst_arvalid", o_arvalid, 0);
         chk("rst_rready", o_rready, 0);
         chk("rst_valid", o_valid, 0);
         chk("rst_pc", o_pc, RST_PC);
      end else begin
         if (p_redir) exp_pc = {p_rpc[31:2], 2'b00};
         else if (p_v && p_rdy) begin
            exp_pc = exp_pc + 32'd4;
            n_deliv++;
         end
         if (p_rr && p_rv) begin
            pending = 0;
            if (p_resp != 2'b00) exp_err = 1;
         end
         if (p_arv && p_arr) begin
            chk("ar_one_outstanding", {31'd0, pending}, 0);
            pending = 1; paddr = p_araddr; rwait = r_delay; ar_cnt = 0; n_ar++;
         end
         if (p_arv && !p_arr) begin
            n_ar_wait++;
            chk("ar_hold_valid", o_arvalid, 1);
            chk("ar_hold_addr", o_araddr, p_araddr);
         end
      end
      chk("fetch_err", o_fetch_err, exp_err);
      if (o_valid) begin
         chk("deliv_pc", o_pc, exp_pc);
         chk("deliv_ins", o_ins, memf(o_pc));
      end
      // drive the memory side for the next edge
      i_arready = 0; i_rvalid = 0; i_rresp = 2'b00; i_rdata = '0;
      if (o_arvalid) begin
         i_arready = rnd_mode ? ($urandom_range(0, 2) != 0) : (ar_cnt >= ar_delay);
         ar_cnt++;
      end
      if (pending) begin
         if (rnd_mode ? ($urandom_range(0, 2) != 0) : (rwait == 0)) begin
            i_rvalid = 1;
            i_rdata  = memf(paddr);
            i_rresp  = rnd_mode ? (($urandom_range(0, 63) == 0) ? 2'b10 : 2'b00) : resp_knob;
         end else if (!rnd_mode) rwait--;
      end
   endtask

   task automatic wait_valid(input int maxc);
      int c = 0;
      while (!o_valid && c < maxc) begin
         tick();
         c++;
      end
      chk("wait_valid_timeout", {31'd0, o_valid}, 1);
   endtask

   initial begin
      logic [31:0] pc0, ins0, first_ar;
      int w0, a0, c;
      bit got;
      i_rst = 1; i_redirect = 0; i_redirect_pc = '0; i_ready = 1;
      i_arready = 0; i_rvalid = 0; i_rdata = '0; i_rresp = 2'b00;
      tick(); tick();
      chk("rst_ins", o_ins, 0);
      chk("rst_err", o_fetch_err, 0);

      // basic zero-wait fetch and latency
      i_rst = 0;
      tick();
      chk("first_arvalid", o_arvalid, 1);
      chk("first_araddr", o_araddr, 32'h8000_0000);
      tick();
      chk("resp_rready", o_rready, 1);
      tick();
      chk("lat_valid", o_valid, 1);
      chk("lat_pc", o_pc, 32'h8000_0000);
      chk("lat_ins", o_ins, 32'h0000_0013);
      tick();
      chk("next_valid_low", o_valid, 0);
      chk("next_araddr", o_araddr, 32'h8000_0004);

      // decode stall for 5 cycles
      i_ready = 0;
      fixed_data = 0;
      wait_valid(20);
      pc0 = o_pc; ins0 = o_ins;
      chk("stall_pc0", pc0, 32'h8000_0004);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("stall_valid", o_valid, 1);
         chk("stall_pc", o_pc, pc0);
         chk("stall_ins", o_ins, ins0);
         chk("stall_no_ar", o_arvalid, 0);
      end
      ar_delay = 4;
      i_ready = 1;
      tick();
      chk("unstall_valid", o_valid, 0);
      chk("unstall_araddr", o_araddr, pc0 + 32'd4);

      // AR accepted only after 4 waiting cycles
      w0 = n_ar_wait; a0 = n_ar; c = 0;
      while (n_ar == a0 && c < 20) begin tick(); c++; end
      chk("ar_wait_cycles", n_ar_wait - w0, 4);
      chk("ar_handshakes", n_ar - a0, 1);
      ar_delay = 0;
      wait_valid(20);

      // redirect during RESP drops the in-flight beat
      r_delay = 3;
      tick();
      c = 0;
      while (!o_rready && c < 20) begin tick(); c++; end
      chk("in_resp", o_rready, 1);
      i_redirect = 1; i_redirect_pc = 32'h8000_0100;
      tick();
      got = 0; first_ar = '0; c = 0;
      while (!o_valid && c < 40) begin
         if (o_arvalid && !got) begin got = 1; first_ar = o_araddr; end
         tick(); c++;
      end
      chk("redir_resp_araddr", first_ar, 32'h8000_0100);
      chk("redir_resp_pc", o_pc, 32'h8000_0100);
      r_delay = 0;

      // redirect beats a same-cycle accept in OUT
      i_ready = 0;
      tick();
      wait_valid(20);
      i_redirect = 1; i_redirect_pc = 32'h8000_0203; i_ready = 1;
      tick();
      chk("redir_out_valid", o_valid, 0);
      chk("redir_out_arvalid", o_arvalid, 1);
      chk("redir_out_araddr", o_araddr, 32'h8000_0200);

      // error response is sticky until reset
      i_ready = 0;
      wait_valid(20);
      resp_knob = 2'b10;
      i_ready = 1;
      tick();
      wait_valid(20);
      chk("err_set", o_fetch_err, 1);
      resp_knob = 2'b00;
      for (int i = 0; i < 2; i++) begin tick(); wait_valid(20); end
      chk("err_sticky", o_fetch_err, 1);
      i_rst = 1;
      tick();
      i_rst = 0;
      chk("err_cleared", o_fetch_err, 0);

      // PC wrap
      wait_valid(20);
      i_redirect = 1; i_redirect_pc = 32'hFFFF_FFFC; i_ready = 0;
      tick();
      wait_valid(20);
      chk("wrap_pc", o_pc, 32'hFFFF_FFFC);
      i_ready = 1;
      tick();
      chk("wrap_arvalid", o_arvalid, 1);
      chk("wrap_araddr", o_araddr, 32'h0000_0000);

      // randomized traffic against the model
      rnd_mode = 1;
      n_deliv = 0;
      for (int i = 0; i < 2000; i++) begin
         i_ready = ($urandom_range(0, 1) == 1);
         i_rst = ($urandom_range(0, 299) == 0);
         if ($urandom_range(0, 19) == 0) begin
            i_redirect = 1; i_redirect_pc = $urandom;
         end
         tick();
      end
      i_rst = 0;
      chk("rand_progress", {31'd0, (n_deliv > 20)}, 1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
